// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// between a single-cycle core data port and a multi-cycle main memory.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-low reset
//   cpu_rd/cpu_wr   load/store request, held by the core while stall=1
//   cpu_addr        byte address (bits [1:0] ignored)
//   cpu_wdata       store data
//   cpu_rdata       load data (meaningful on a hit with stall=0)
//   stall           freezes the core during refills and write-throughs
//   mem_rd/mem_wr   main-memory word read/write request
//   mem_addr        main-memory byte address of the current word
//   mem_wdata       main-memory write data
//   mem_rdata       main-memory read data, valid with mem_ready
//   mem_ready       main memory accepts/completes the current word
module dcache_ctrl #(
    parameter int INDEX_BITS  = 5,
    parameter int OFFSET_BITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;
    localparam int LSB      = OFFSET_BITS + 2;
    localparam int TAG_LSB  = LSB + INDEX_BITS;
    localparam int TAG_BITS = 32 - TAG_LSB;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE,
        WDONE
    } state_t;

    state_t state, state_n;

    logic [TAG_BITS-1:0] tag_arr [LINES];
    logic [31:0]         data_arr[LINES*WORDS];
    logic [LINES-1:0]    valid;

    logic [OFFSET_BITS-1:0] cnt, cnt_n;
    logic        mem_rd_n, mem_wr_n;
    logic [31:0] mem_addr_n, mem_wdata_n;

    logic fill_we, store_we, line_done;

    logic [OFFSET_BITS-1:0] offset, w_offset;
    logic [INDEX_BITS-1:0]  index, w_index;
    logic [TAG_BITS-1:0]    tag, w_tag;
    logic hit, w_hit;

    logic unused_bits;
    assign unused_bits = ^{cpu_addr[1:0], mem_addr[1:0]};

    assign offset = cpu_addr[LSB-1:2];
    assign index  = cpu_addr[TAG_LSB-1:LSB];
    assign tag    = cpu_addr[31:TAG_LSB];

    // Fields of the store being written through, taken from the
    // latched memory address rather than the live core address.
    assign w_offset = mem_addr[LSB-1:2];
    assign w_index  = mem_addr[TAG_LSB-1:LSB];
    assign w_tag    = mem_addr[31:TAG_LSB];

    assign hit   = valid[index] && (tag_arr[index] == tag);
    assign w_hit = valid[w_index] && (tag_arr[w_index] == w_tag);

    assign cpu_rdata = data_arr[{index, offset}];

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        mem_rd_n    = mem_rd;
        mem_wr_n    = mem_wr;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        stall       = 1'b0;
        fill_we     = 1'b0;
        store_we    = 1'b0;
        line_done   = 1'b0;
        unique case (state)
            IDLE: begin
                // A store wins when both requests are raised.
                if (cpu_wr) begin
                    stall       = 1'b1;
                    state_n     = WRITE;
                    mem_wr_n    = 1'b1;
                    mem_addr_n  = {cpu_addr[31:2], 2'b00};
                    mem_wdata_n = cpu_wdata;
                end else if (cpu_rd && !hit) begin
                    stall      = 1'b1;
                    state_n    = REFILL;
                    cnt_n      = '0;
                    mem_rd_n   = 1'b1;
                    mem_addr_n = {cpu_addr[31:LSB], {LSB{1'b0}}};
                end
            end
            REFILL: begin
                stall = 1'b1;
                if (mem_ready) begin
                    fill_we    = 1'b1;
                    cnt_n      = cnt + 1'b1;
                    mem_addr_n = mem_addr + 32'd4;
                    if (&cnt) begin
                        line_done = 1'b1;
                        mem_rd_n  = 1'b0;
                        state_n   = IDLE;
                    end
                end
            end
            WRITE: begin
                stall = 1'b1;
                if (mem_ready) begin
                    store_we = w_hit;
                    mem_wr_n = 1'b0;
                    state_n  = WDONE;
                end
            end
            // The core retires the store here; its held request is
            // not re-issued.
            WDONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            valid     <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            mem_rd    <= mem_rd_n;
            mem_wr    <= mem_wr_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            if (line_done) begin
                valid[index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (fill_we) begin
                data_arr[{index, cnt}] <= mem_rdata;
            end
            if (store_we) begin
                data_arr[{w_index, w_offset}] <= mem_wdata;
            end
            if (line_done) begin
                tag_arr[index] <= tag;
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl with a latency-scripted
// main-memory responder and a line/tag reference model.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        stall;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    always #5 clk = ~clk;

    dcache_ctrl #(.INDEX_BITS(5), .OFFSET_BITS(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    typedef struct {
        bit          ld;
        logic [31:0] data;
        int          stalls;
    } comp_t;

    int checks = 0;
    int failures = 0;

    comp_t       comp_q[$];
    logic [31:0] rf_q[$];
    logic [63:0] wr_q[$];
    int          lat_q[$];

    logic [31:0] mem_model[4096];
    logic [31:0] ref_mem[4096];
    bit          ref_valid[32];
    int          ref_tag[32];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expect_op(input bit rd, input bit wr,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int l0, input int l1,
                             input int l2, input int l3);
        int ln, idx, tg, w;
        comp_t c;
        ln  = int'(addr >> 4);
        idx = ln % 32;
        tg  = ln / 32;
        w   = int'((addr >> 2) & 32'hFFF);
        if (wr) begin
            lat_q.push_back(l0);
            wr_q.push_back({addr[31:2], 2'b00, wd});
            ref_mem[w] = wd;
            c.ld     = 1'b0;
            c.data   = '0;
            c.stalls = l0 + 2;
        end else begin
            c.ld = 1'b1;
            if (rd && ref_valid[idx] && ref_tag[idx] == tg) begin
                c.stalls = 0;
            end else begin
                lat_q.push_back(l0);
                lat_q.push_back(l1);
                lat_q.push_back(l2);
                lat_q.push_back(l3);
                for (int k = 0; k < 4; k++) begin
                    rf_q.push_back(32'(ln * 16 + k * 4));
                end
                c.stalls = 5 + l0 + l1 + l2 + l3;
                ref_valid[idx] = 1'b1;
                ref_tag[idx]   = tg;
            end
            c.data = ref_mem[w];
        end
        comp_q.push_back(c);
    endtask

    task automatic do_op(input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int l0, input int l1,
                         input int l2, input int l3);
        int n;
        expect_op(rd, wr, addr, wd, l0, l1, l2, l3);
        @(posedge clk);
        #1;
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_addr  = addr;
        cpu_wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall && n < 200);
        if (stall) check("op_timeout", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    // Main-memory responder: each new word takes the next scripted
    // latency; ready with no request is raised at random.
    int wait_cnt = 0;
    bit busy = 1'b0;
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_rd || mem_wr) begin
                if (!busy) begin
                    busy = 1'b1;
                    if (lat_q.size() == 0) begin
                        check("unexpected_mem_req",
                              {30'b0, mem_rd, mem_wr}, 32'd0);
                        wait_cnt = 0;
                    end else begin
                        wait_cnt = lat_q.pop_front();
                    end
                end
                if (wait_cnt == 0) begin
                    busy      = 1'b0;
                    mem_ready = 1'b1;
                    if (mem_rd) mem_rdata = mem_model[mem_addr[13:2]];
                    else mem_model[mem_addr[13:2]] = mem_wdata;
                end else begin
                    mem_ready = 1'b0;
                    wait_cnt--;
                end
            end else begin
                busy      = 1'b0;
                mem_ready = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a memory
    // handshake or retires a core request.
    int sc = 0;
    bit prev_hold = 1'b0;
    logic [31:0] prev_a, prev_d;
    initial begin
        comp_t c;
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                sc = 0;
                prev_hold = 1'b0;
            end else begin
                if (mem_rd || mem_wr) begin
                    check("rd_wr_exclusive", {31'b0, mem_rd & mem_wr}, 32'd0);
                end
                if (prev_hold && mem_wr) begin
                    check("wr_addr_hold", mem_addr, prev_a);
                    check("wr_data_hold", mem_wdata, prev_d);
                end
                prev_hold = mem_wr && !mem_ready;
                prev_a    = mem_addr;
                prev_d    = mem_wdata;
                if (mem_ready && mem_rd) begin
                    if (rf_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL refill_unexpected actual=%h required=none",
                                 mem_addr);
                    end else begin
                        check("refill_addr", mem_addr, rf_q.pop_front());
                    end
                end
                if (mem_ready && mem_wr) begin
                    if (wr_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL write_unexpected actual=%h required=none",
                                 mem_addr);
                    end else begin
                        e = wr_q.pop_front();
                        check("wr_addr", mem_addr, e[63:32]);
                        check("wr_data", mem_wdata, e[31:0]);
                    end
                end
                if (cpu_rd || cpu_wr) begin
                    if (stall) begin
                        sc++;
                    end else if (comp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_completion actual=%h required=none",
                                 cpu_addr);
                        sc = 0;
                    end else begin
                        c = comp_q.pop_front();
                        check("stall_cycles", sc, c.stalls);
                        if (c.ld) check("ld_data", cpu_rdata, c.data);
                        sc = 0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r;
        bit rd, wr;
        logic [31:0] a;
        for (int i = 0; i < 4096; i++) begin
            mem_model[i] = 32'hA500_0000 ^ (i * 32'h0001_0003);
            ref_mem[i]   = 32'hA500_0000 ^ (i * 32'h0001_0003);
        end
        for (int i = 0; i < 32; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = 0;
        end
        reset     = 1'b0;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
        check("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        do_op(1, 0, 32'h40, 0, 0, 0, 0, 0);
        do_op(1, 0, 32'h44, 0, 0, 0, 0, 0);
        do_op(0, 1, 32'h44, 32'hDEAD_BEEF, 0, 0, 0, 0);
        do_op(1, 0, 32'h44, 0, 0, 0, 0, 0);
        do_op(0, 1, 32'h1000, 32'h1234_5678, 1, 0, 0, 0);
        do_op(1, 0, 32'h1000, 0, 1, 0, 2, 0);
        do_op(1, 0, 32'h840, 0, 0, 1, 0, 1);
        do_op(1, 0, 32'h40, 0, 2, 0, 0, 0);
        do_op(0, 1, 32'h48, 32'hCAFE_F00D, 10, 0, 0, 0);
        do_op(1, 0, 32'h48, 0, 0, 0, 0, 0);
        do_op(1, 1, 32'h4C, 32'h0BAD_CAFE, 1, 0, 0, 0);
        do_op(1, 0, 32'h4C, 0, 0, 0, 0, 0);

        expect_op(1, 0, 32'h80, 0, 0, 3, 0, 0);
        @(posedge clk);
        #1;
        cpu_rd   = 1'b1;
        cpu_addr = 32'h80;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_rd && mem_addr == 32'h84) && n < 50);
        check("rst_reach_word1", mem_addr, 32'h84);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        cpu_rd = 1'b0;
        lat_q.delete();
        rf_q.delete();
        comp_q.delete();
        for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_mem_rd", {31'b0, mem_rd}, 32'd0);
        check("rst_mid_mem_addr", mem_addr, 32'd0);
        check("rst_mid_stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        do_op(1, 0, 32'h80, 0, 0, 0, 0, 0);
        do_op(1, 0, 32'h8C, 0, 0, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            r  = int'($urandom_range(0, 9));
            rd = (r < 6) || (r == 9);
            wr = (r >= 6);
            a  = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 4)
               | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            do_op(rd, wr, a, $urandom,
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        repeat (3) @(posedge clk);
        check("comp_q_drained", 32'(comp_q.size()), 32'd0);
        check("rf_q_drained", 32'(rf_q.size()), 32'd0);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("lat_q_drained", 32'(lat_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
